// File: rtl/maze_move_multi.sv
// rtl/maze_move_multi.sv - multi-player maze token mover with wall checks, cooldown and winner arbitration
// Decodes arrow/WASD make codes into wall-checked moves for up to two tokens on a path bitmap.
module maze_move_multi #(
   parameter int NUM_PLAYERS = 2,
   parameter int WIDTH       = 16,
   parameter int HEIGHT      = 16,
   parameter int COORD_W     = 5,
   parameter int CNT_W       = 10,
   parameter int COOLDOWN    = 2_000_000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           load,
   input  logic                           key_valid,
   input  logic [7:0]                     key_code,
   input  logic [WIDTH*HEIGHT-1:0]        maze_data,
   input  logic [COORD_W-1:0]             start_x,
   input  logic [COORD_W-1:0]             start_y,
   input  logic [COORD_W-1:0]             finish_x,
   input  logic [COORD_W-1:0]             finish_y,
   output logic [NUM_PLAYERS*COORD_W-1:0] pos_x,
   output logic [NUM_PLAYERS*COORD_W-1:0] pos_y,
   output logic [NUM_PLAYERS*CNT_W-1:0]   move_cnt,
   output logic                           moved,
   output logic                           bumped,
   output logic                           win,
   output logic                           winner
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_WON  = 2'd2;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam int IDX_W = $clog2(WIDTH * HEIGHT);

   logic [1:0]                     state_q, state_d;
   logic [NUM_PLAYERS*COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [NUM_PLAYERS*CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_PLAYERS*CD_W-1:0]    cd_q, cd_d;
   logic                           moved_q, moved_d, bumped_q, bumped_d;
   logic                           win_q, win_d, winner_q, winner_d;

   logic                           key_map, key_p, p_idx;
   logic [1:0]                     key_dir;
   logic [COORD_W-1:0]             cur_x, cur_y, tx, ty;
   logic [CNT_W-1:0]               cur_cnt;
   logic [CD_W-1:0]                cur_cd;
   logic [IDX_W-1:0]               idx;
   logic                           edge_ok, cell_open, do_eval, accept, blocked;

   always_comb begin
      key_map = 1'b0;
      key_p   = 1'b0;
      key_dir = DIR_UP;
      case (key_code)
         8'hEA: begin key_map = 1'b1; key_dir = DIR_UP;    end
         8'hE4: begin key_map = 1'b1; key_dir = DIR_DOWN;  end
         8'hD6: begin key_map = 1'b1; key_dir = DIR_LEFT;  end
         8'hE8: begin key_map = 1'b1; key_dir = DIR_RIGHT; end
         8'h3A: begin key_map = (NUM_PLAYERS > 1); key_p = 1'b1; key_dir = DIR_UP;    end
         8'h36: begin key_map = (NUM_PLAYERS > 1); key_p = 1'b1; key_dir = DIR_DOWN;  end
         8'h38: begin key_map = (NUM_PLAYERS > 1); key_p = 1'b1; key_dir = DIR_LEFT;  end
         8'h46: begin key_map = (NUM_PLAYERS > 1); key_p = 1'b1; key_dir = DIR_RIGHT; end
         default: ;
      endcase
   end

   assign p_idx   = (NUM_PLAYERS > 1) ? key_p : 1'b0;
   assign cur_x   = pos_x_q[int'(p_idx)*COORD_W +: COORD_W];
   assign cur_y   = pos_y_q[int'(p_idx)*COORD_W +: COORD_W];
   assign cur_cnt = cnt_q[int'(p_idx)*CNT_W +: CNT_W];
   assign cur_cd  = cd_q[int'(p_idx)*CD_W +: CD_W];

   // Target stays on the current cell when the edge blocks, keeping the bitmap index in range.
   always_comb begin
      edge_ok = 1'b0;
      tx      = cur_x;
      ty      = cur_y;
      case (key_dir)
         DIR_UP:    if (cur_y != '0)                   begin edge_ok = 1'b1; ty = cur_y - COORD_W'(1); end
         DIR_DOWN:  if (cur_y < COORD_W'(HEIGHT - 1))  begin edge_ok = 1'b1; ty = cur_y + COORD_W'(1); end
         DIR_LEFT:  if (cur_x != '0)                   begin edge_ok = 1'b1; tx = cur_x - COORD_W'(1); end
         default:   if (cur_x < COORD_W'(WIDTH - 1))   begin edge_ok = 1'b1; tx = cur_x + COORD_W'(1); end
      endcase
   end

   assign idx       = IDX_W'(ty) * IDX_W'(WIDTH) + IDX_W'(tx);
   assign cell_open = maze_data[idx];
   assign do_eval   = (state_q == ST_PLAY) && enable && key_valid && key_map
                      && (cur_cd == '0) && !load;
   assign accept    = do_eval && edge_ok && cell_open;
   assign blocked   = do_eval && !accept;

   always_comb begin
      state_d  = state_q;
      pos_x_d  = pos_x_q;
      pos_y_d  = pos_y_q;
      cnt_d    = cnt_q;
      win_d    = win_q;
      winner_d = winner_q;
      moved_d  = 1'b0;
      bumped_d = 1'b0;
      cd_d     = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (cd_q[p*CD_W +: CD_W] != '0)
            cd_d[p*CD_W +: CD_W] = cd_q[p*CD_W +: CD_W] - CD_W'(1);
      end
      if (load) begin
         state_d  = ST_PLAY;
         cnt_d    = '0;
         cd_d     = '0;
         win_d    = 1'b0;
         winner_d = 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            pos_x_d[p*COORD_W +: COORD_W] = start_x;
            pos_y_d[p*COORD_W +: COORD_W] = start_y;
         end
      end else begin
         bumped_d = blocked;
         if (accept) begin
            moved_d = 1'b1;
            pos_x_d[int'(p_idx)*COORD_W +: COORD_W] = tx;
            pos_y_d[int'(p_idx)*COORD_W +: COORD_W] = ty;
            cd_d[int'(p_idx)*CD_W +: CD_W]          = CD_W'(COOLDOWN);
            if (cur_cnt != {CNT_W{1'b1}})
               cnt_d[int'(p_idx)*CNT_W +: CNT_W] = cur_cnt + CNT_W'(1);
            if ((tx == finish_x) && (ty == finish_y)) begin
               state_d  = ST_WON;
               win_d    = 1'b1;
               winner_d = p_idx;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pos_x_q  <= '0;
         pos_y_q  <= '0;
         cnt_q    <= '0;
         cd_q     <= '0;
         moved_q  <= 1'b0;
         bumped_q <= 1'b0;
         win_q    <= 1'b0;
         winner_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_x_q  <= pos_x_d;
         pos_y_q  <= pos_y_d;
         cnt_q    <= cnt_d;
         cd_q     <= cd_d;
         moved_q  <= moved_d;
         bumped_q <= bumped_d;
         win_q    <= win_d;
         winner_q <= winner_d;
      end
   end

   assign pos_x    = pos_x_q;
   assign pos_y    = pos_y_q;
   assign move_cnt = cnt_q;
   assign moved    = moved_q;
   assign bumped   = bumped_q;
   assign win      = win_q;
   assign winner   = winner_q;

endmodule

// File: tb/tb_maze_move_multi.sv
// tb/tb_maze_move_multi.sv - directed table, corner sequences and random run against a cell-level reference model
module tb_maze_move_multi;

   localparam int NP   = 2;
   localparam int W    = 16;
   localparam int H    = 16;
   localparam int CW   = 5;
   localparam int CNTW = 2;
   localparam int CD   = 10;

   logic                clk = 1'b0;
   logic                reset, enable, load, key_valid;
   logic [7:0]          key_code;
   logic [W*H-1:0]      maze;
   logic [CW-1:0]       sx, sy, fx, fy;
   logic [NP*CW-1:0]    pos_x, pos_y;
   logic [NP*CNTW-1:0]  move_cnt;
   logic                moved, bumped, win, winner;

   int n_checks = 0;
   int n_fail   = 0;

   int m_mode;
   int m_px[NP], m_py[NP], m_cnt[NP], m_cd[NP];
   int m_moved, m_bumped, m_win, m_winner;

   typedef struct {
      logic       ld, kv;
      logic [7:0] kc;
      logic       en, msel, fsel;
      int         gap;
      int         ex0, ey0, ex1, ey1, ec0, ec1;
      int         emv, ebp, ewin, ewnr;
   } vec_t;

   vec_t vt[$];
   logic [7:0] codes[10] = '{8'hEA, 8'hE4, 8'hD6, 8'hE8, 8'h3A, 8'h36, 8'h38, 8'h46, 8'h1C, 8'h00};

   maze_move_multi #(
      .NUM_PLAYERS(NP), .WIDTH(W), .HEIGHT(H), .COORD_W(CW), .CNT_W(CNTW), .COOLDOWN(CD)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .key_valid(key_valid), .key_code(key_code), .maze_data(maze),
      .start_x(sx), .start_y(sy), .finish_x(fx), .finish_y(fy),
      .pos_x(pos_x), .pos_y(pos_y), .move_cnt(move_cnt),
      .moved(moved), .bumped(bumped), .win(win), .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_moved = 0; m_bumped = 0; m_win = 0; m_winner = 0;
      for (int p = 0; p < NP; p++) begin
         m_px[p] = 0; m_py[p] = 0; m_cnt[p] = 0; m_cd[p] = 0;
      end
   endtask

   // mode: 0 idle, 1 play, 2 won; moves are vector offsets on the cell grid
   task automatic model_step();
      int p, dx, dy, tx, ty;
      bit ok;
      p = -1; dx = 0; dy = 0; ok = 0;
      case (key_code)
         8'hEA: begin p = 0; dy = -1; end
         8'hE4: begin p = 0; dy = 1;  end
         8'hD6: begin p = 0; dx = -1; end
         8'hE8: begin p = 0; dx = 1;  end
         8'h3A: begin p = 1; dy = -1; end
         8'h36: begin p = 1; dy = 1;  end
         8'h38: begin p = 1; dx = -1; end
         8'h46: begin p = 1; dx = 1;  end
         default: p = -1;
      endcase
      if (p >= NP) p = -1;
      m_moved = 0; m_bumped = 0;
      if (load) begin
         m_mode = 1; m_win = 0; m_winner = 0;
         for (int q = 0; q < NP; q++) begin
            m_px[q] = sx; m_py[q] = sy; m_cnt[q] = 0; m_cd[q] = 0;
         end
      end else begin
         if (m_mode == 1 && enable && key_valid && p >= 0) ok = (m_cd[p] == 0);
         for (int q = 0; q < NP; q++) if (m_cd[q] > 0) m_cd[q] = m_cd[q] - 1;
         if (ok) begin
            tx = m_px[p] + dx;
            ty = m_py[p] + dy;
            ok = (tx >= 0 && tx < W && ty >= 0 && ty < H);
            if (ok) ok = (maze[ty*W + tx] == 1'b1);
            if (ok) begin
               m_px[p] = tx; m_py[p] = ty;
               if (m_cnt[p] < (1 << CNTW) - 1) m_cnt[p] = m_cnt[p] + 1;
               m_cd[p] = CD;
               m_moved = 1;
               if (tx == fx && ty == fy) begin
                  m_mode = 2; m_win = 1; m_winner = p;
               end
            end else begin
               m_bumped = 1;
            end
         end
      end
   endtask

   task automatic check_dut();
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("m_pos_x%0d", p), int'(pos_x[p*CW +: CW]), m_px[p]);
         chk($sformatf("m_pos_y%0d", p), int'(pos_y[p*CW +: CW]), m_py[p]);
         chk($sformatf("m_cnt%0d", p), int'(move_cnt[p*CNTW +: CNTW]), m_cnt[p]);
      end
      chk("m_moved", int'(moved), m_moved);
      chk("m_bumped", int'(bumped), m_bumped);
      chk("m_win", int'(win), m_win);
      if (m_win == 1) chk("m_winner", int'(winner), m_winner);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_dut();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_pos_x"}, int'(pos_x), 0);
      chk({tag, "_pos_y"}, int'(pos_y), 0);
      chk({tag, "_cnt"}, int'(move_cnt), 0);
      chk({tag, "_flags"}, int'({moved, bumped, win, winner}), 0);
   endtask

   task automatic push(input logic ld, input logic kv, input logic [7:0] kc, input logic en,
                       input logic msel, input logic fsel, input int gap,
                       input int ex0, input int ey0, input int ex1, input int ey1,
                       input int ec0, input int ec1, input int emv, input int ebp,
                       input int ewin, input int ewnr);
      vec_t v;
      v.ld = ld; v.kv = kv; v.kc = kc; v.en = en; v.msel = msel; v.fsel = fsel; v.gap = gap;
      v.ex0 = ex0; v.ey0 = ey0; v.ex1 = ex1; v.ey1 = ey1; v.ec0 = ec0; v.ec1 = ec1;
      v.emv = emv; v.ebp = ebp; v.ewin = ewin; v.ewnr = ewnr;
      vt.push_back(v);
   endtask

   initial begin
      // ld kv code en msel fsel gap | p0x p0y p1x p1y c0 c1 | mv bp win wnr
      push(0, 1, 8'hE8, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
      push(1, 0, 8'h00, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
      push(0, 1, 8'hD6, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
      push(0, 1, 8'hEA, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
      push(0, 1, 8'hE8, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
      push(0, 1, 8'hE4, 1, 0, 0, 4,   0, 1, 0, 0, 1, 0,   1, 0, 0, 0);
      push(0, 1, 8'hE4, 1, 0, 0, 0,   0, 1, 0, 0, 1, 0,   0, 0, 0, 0);
      push(0, 1, 8'h46, 1, 0, 0, 2,   0, 1, 1, 0, 1, 1,   1, 0, 0, 0);
      push(0, 1, 8'hE8, 1, 0, 0, 0,   0, 1, 1, 0, 1, 1,   0, 0, 0, 0);
      push(0, 1, 8'hE8, 1, 0, 0, 0,   0, 1, 1, 0, 1, 1,   0, 0, 0, 0);
      push(0, 1, 8'hE8, 1, 0, 0, 10,  1, 1, 1, 0, 2, 1,   1, 0, 0, 0);
      push(0, 1, 8'hE8, 1, 0, 0, 10,  2, 1, 1, 0, 3, 1,   1, 0, 0, 0);
      push(0, 1, 8'h46, 1, 0, 0, 0,   2, 1, 2, 0, 3, 2,   1, 0, 1, 1);
      push(0, 1, 8'hEA, 1, 0, 0, 0,   2, 1, 2, 0, 3, 2,   0, 0, 1, 1);
      push(1, 1, 8'hE4, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
      push(0, 1, 8'hE4, 1, 0, 0, 10,  0, 1, 0, 0, 1, 0,   1, 0, 0, 0);
      push(0, 1, 8'hEA, 1, 0, 0, 10,  0, 0, 0, 0, 2, 0,   1, 0, 0, 0);
      push(0, 1, 8'hE4, 1, 0, 0, 10,  0, 1, 0, 0, 3, 0,   1, 0, 0, 0);
      push(0, 1, 8'hEA, 1, 0, 0, 10,  0, 0, 0, 0, 3, 0,   1, 0, 0, 0);
      push(0, 1, 8'hE4, 1, 0, 0, 10,  0, 1, 0, 0, 3, 0,   1, 0, 0, 0);
      push(0, 1, 8'h1C, 1, 0, 0, 0,   0, 1, 0, 0, 3, 0,   0, 0, 0, 0);
      push(0, 1, 8'hE8, 0, 0, 0, 0,   0, 1, 0, 0, 3, 0,   0, 0, 0, 0);
      push(1, 0, 8'h00, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
      push(0, 1, 8'hE4, 1, 0, 1, 10,  0, 1, 0, 0, 1, 0,   1, 0, 0, 0);
      push(0, 1, 8'hEA, 1, 0, 1, 0,   0, 0, 0, 0, 2, 0,   1, 0, 1, 0);

      reset = 1'b1; enable = 1'b1; load = 1'b0; key_valid = 1'b0; key_code = 8'h00;
      maze = '1; sx = '0; sy = '0; fx = 5'd2; fy = 5'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b0;

      for (int i = 0; i < vt.size(); i++) begin
         load = vt[i].ld; key_valid = vt[i].kv; key_code = vt[i].kc; enable = vt[i].en;
         maze = '1;
         if (vt[i].msel) maze[1] = 1'b0;
         fx = vt[i].fsel ? 5'd0 : 5'd2;
         fy = 5'd0;
         tick();
         chk($sformatf("row%0d_p0x", i), int'(pos_x[CW-1:0]), vt[i].ex0);
         chk($sformatf("row%0d_p0y", i), int'(pos_y[CW-1:0]), vt[i].ey0);
         chk($sformatf("row%0d_p1x", i), int'(pos_x[2*CW-1:CW]), vt[i].ex1);
         chk($sformatf("row%0d_p1y", i), int'(pos_y[2*CW-1:CW]), vt[i].ey1);
         chk($sformatf("row%0d_cnt0", i), int'(move_cnt[CNTW-1:0]), vt[i].ec0);
         chk($sformatf("row%0d_cnt1", i), int'(move_cnt[2*CNTW-1:CNTW]), vt[i].ec1);
         chk($sformatf("row%0d_moved", i), int'(moved), vt[i].emv);
         chk($sformatf("row%0d_bumped", i), int'(bumped), vt[i].ebp);
         chk($sformatf("row%0d_win", i), int'(win), vt[i].ewin);
         if (vt[i].ewin == 1) chk($sformatf("row%0d_winner", i), int'(winner), vt[i].ewnr);
         load = 1'b0; key_valid = 1'b0; key_code = 8'h00; enable = 1'b1;
         repeat (vt[i].gap) tick();
      end

      for (int i = 0; i < W*H; i++) maze[i] = ($urandom_range(0, 4) != 0);
      fx = CW'($urandom_range(0, W-1)); fy = CW'($urandom_range(0, H-1));
      load = 1'b1;
      tick();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 49) == 0) begin
            for (int i = 0; i < W*H; i++) maze[i] = ($urandom_range(0, 4) != 0);
            fx = CW'($urandom_range(0, W-1)); fy = CW'($urandom_range(0, H-1));
            sx = CW'($urandom_range(0, W-1)); sy = CW'($urandom_range(0, H-1));
         end
         load      = ($urandom_range(0, 199) == 0);
         key_valid = ($urandom_range(0, 1) == 1);
         key_code  = codes[$urandom_range(0, 9)];
         enable    = ($urandom_range(0, 9) != 0);
         tick();
      end

      maze = '1; sx = '0; sy = '0; fx = 5'd15; fy = 5'd15;
      load = 1'b1; key_valid = 1'b0; enable = 1'b1;
      tick();
      load = 1'b0;
      for (int m = 0; m < 7; m++) begin
         key_valid = 1'b1;
         key_code  = (m < 3) ? 8'hE8 : 8'hE4;
         tick();
         key_valid = 1'b0;
         repeat (10) tick();
      end
      chk("mid_p0x", int'(pos_x[CW-1:0]), 3);
      chk("mid_p0y", int'(pos_y[CW-1:0]), 4);
      #2 reset = 1'b1;
      #1;
      check_zero("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      key_valid = 1'b1; key_code = 8'hE8;
      tick();
      key_valid = 1'b1; key_code = 8'h46;
      tick();
      key_valid = 1'b0;
      check_zero("idle_keys");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/maze_move_multi.md
Name: maze_move_multi

Overview:
Parametrised successor to the single-player maze mover. It tracks 1 or 2 player tokens on a WIDTH x HEIGHT path bitmap and decodes keyboard codes into wall-checked moves. Per-player move cooldown, saturating move counters and first-to-finish winner arbitration are included. It sits between kb_code and the renderer in the maze top level and is enabled by the game state machine during the move phase.

Parameters:
NUM_PLAYERS, 2, number of tokens (1 or 2); player 0 uses arrows, player 1 uses WASD
WIDTH, 16, maze width in cells (2..31)
HEIGHT, 16, maze height in cells (2..31)
COORD_W, 5, coordinate width in bits
CNT_W, 10, per-player move counter width
COOLDOWN, 2_000_000, cycles after an accepted move before that player may move again (0 = no limit)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  moves accepted only when high
load  in  1  single-cycle pulse: place all tokens at start, clear stats, enter PLAY
key_valid  in  1  single-cycle strobe qualifying key_code
key_code  in  8  keyboard make code
maze_data  in  WIDTH*HEIGHT  path bitmap; bit y*WIDTH+x = 1 means open cell
start_x, start_y  in  COORD_W each  common start cell
finish_x, finish_y  in  COORD_W each  finish cell
pos_x, pos_y  out  NUM_PLAYERS*COORD_W each  token positions; player p occupies slice [p*COORD_W +: COORD_W]
move_cnt  out  NUM_PLAYERS*CNT_W  accepted-move counters
moved  out  1  one-cycle pulse on an accepted move
bumped  out  1  one-cycle pulse on a move blocked by a wall or the edge
win  out  1  high from the finish cycle until load or reset
winner  out  1  index of the winning player; valid while win=1

Behaviour:
- Asynchronous reset: state=IDLE; all pos_x/pos_y=0; move_cnt=0; cooldowns=0; moved, bumped, win, winner = 0.
- States: IDLE -> (load) -> PLAY -> (token reaches finish) -> WON -> (load) -> PLAY. Keys are ignored in IDLE and WON.
- load, in any state: next edge sets every token to (start_x, start_y), clears move_cnt, cooldowns and win, and enters PLAY. If load and key_valid arrive in the same cycle, load wins and the key is dropped.
- Key map, fixed:
  - Player 0: UP 8'hEA, DOWN 8'hE4, LEFT 8'hD6, RIGHT 8'hE8.
  - Player 1: W 8'h3A, S 8'h36, A 8'h38, D 8'h46.
  - Player 1 codes are ignored when NUM_PLAYERS=1. Unmapped codes are ignored with no pulse.
- Move evaluation happens in PLAY with enable=1, key_valid=1, a mapped code, and that player's cooldown = 0.
  - Target: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1.
  - Blocked when the target leaves [0..WIDTH-1] x [0..HEIGHT-1] (no wrap-around), or when maze_data[ty*WIDTH+tx]=0.
  - Edge check precedes the bitmap index, so no out-of-range index is ever formed.
- Accepted move:
  - Position updates on the next edge.
  - moved=1 for one cycle; move_cnt +1, saturating at 2^CNT_W-1.
  - Cooldown loads COOLDOWN.
- Blocked move: bumped=1 for one cycle. Position, counter and cooldown are unchanged.
- Keys arriving while the player's cooldown is nonzero are dropped silently; the other player is unaffected.
- Cooldown counters decrement by 1 per cycle, saturating at 0, in every state.
- Latency: key_valid at edge N -> pos/moved/bumped updated at edge N+1.
- Win: in the cycle a token's new position equals (finish_x, finish_y):
  - state becomes WON, win=1, winner=that player index.
  - Only one key is processed per cycle, so only one player can finish per cycle; winner is never overwritten until load.
- A start cell equal to the finish cell does not produce a win on load. Win is evaluated only on accepted moves.
- enable low in PLAY: keys are ignored, but state and cooldowns still run.
- maze_data is sampled combinationally at evaluation; changes elsewhere have no effect.

Test Plan:
- Reset mid-play with tokens at (3,4): assert reset -> pos=0, move_cnt=0, win=0, state IDLE; keys then ignored until load.
- 16x16 maze, all open, start (0,0), COOLDOWN=0: load, then RIGHT, RIGHT, DOWN -> P0 at (2,1), move_cnt[0]=3, three moved pulses each one cycle after key_valid.
- Edge and wall: P0 at (0,0), LEFT -> bumped, position unchanged. With bit 1 cleared, RIGHT -> bumped, move_cnt unchanged.
- COOLDOWN=10: P0 RIGHT at cycle 0, RIGHT again at cycle 5 -> dropped. P1 D at cycle 5 -> accepted. P0 RIGHT at cycle 12 -> accepted.
- Win: finish (2,0), P1 presses D twice -> win=1, winner=1. Further P0 keys are ignored. Load -> win=0, both tokens back at start.
- Load and key_valid in the same cycle, and CNT_W=2 with 5 moves -> key dropped; move_cnt saturates at 3.
